// File: rtl/seq_mult_cla.sv
// seq_mult_cla: multi-cycle unsigned shift-and-add WIDTH x WIDTH multiplier on a claAdder.
// Optional overflow flag output enabled by defining SEQ_MULT_OVF_EN.
module claAdder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    logic [WIDTH/4:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < WIDTH/4; i++) begin : g_slice
        logic [3:0] g, p, ci;
        assign g = a[4*i +: 4] & b[4*i +: 4];
        assign p = a[4*i +: 4] ^ b[4*i +: 4];
        // full lookahead inside each 4-bit slice, slices chained by group carry
        assign ci[0] = c[i];
        assign ci[1] = g[0] | (p[0] & c[i]);
        assign ci[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[i]);
        assign ci[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[i]);
        assign c[i+1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                      | (&p & c[i]);
        assign s[4*i +: 4] = p ^ ci;
    end
    assign cout = c[WIDTH/4];
endmodule

module seq_mult_cla #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
`ifdef SEQ_MULT_OVF_EN
    output logic               ovf,
`endif
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0]   mcand, acc_hi, acc_lo, add_b, sum;
    logic [CNT_W-1:0]   cnt;
    logic               co, last;
    logic [2*WIDTH-1:0] acc_nx;

    assign last   = cnt == CNT_W'(WIDTH - 1);
    assign add_b  = acc_lo[0] ? mcand : '0;
    // carry becomes the new MSB as the 2*WIDTH+1 bit partial sum shifts right
    assign acc_nx = {co, sum, acc_lo[WIDTH-1:1]};

    claAdder #(.WIDTH(WIDTH)) u_add (
        .a   (acc_hi),
        .b   (add_b),
        .cin (1'b0),
        .s   (sum),
        .cout(co)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = (state == IDLE && in_valid)  ? RUN  :
                   (state == RUN  && last)      ? DONE :
                   (state == DONE && out_ready) ? IDLE : state;
    end

    always_comb begin
        in_ready  = state == IDLE;
        busy      = state == RUN;
        out_valid = state == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (state == IDLE && in_valid) begin
            mcand  <= a;
            acc_hi <= '0;
            acc_lo <= b;
            cnt    <= '0;
        end else if (state == RUN) begin
            {acc_hi, acc_lo} <= acc_nx;
            product          <= acc_nx;
            cnt              <= cnt + CNT_W'(1);
        end
    end

`ifdef SEQ_MULT_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         ovf <= 1'b0;
        else if (state == RUN && last)      ovf <= |acc_nx[2*WIDTH-1:WIDTH];
        else if (state == DONE && out_ready) ovf <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_seq_mult_cla.sv
// tb_seq_mult_cla: directed and randomized checks of seq_mult_cla against plain a*b arithmetic.
module tb_seq_mult_cla;
    localparam int W = 16;
    logic           clk = 1'b0, rst_n = 1'b0;
    logic           in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0]   a = '0, b = '0;
    logic           in_ready, out_valid, busy;
    logic [2*W-1:0] product;
`ifdef SEQ_MULT_OVF_EN
    logic           ovf;
`endif
    int tests = 0, fails = 0;

    seq_mult_cla dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product  (product),
`ifdef SEQ_MULT_OVF_EN
        .ovf      (ovf),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ovf(input string tag, input logic exp);
`ifdef SEQ_MULT_OVF_EN
        chk(tag, 64'(ovf), 64'(exp));
`else
        if (exp === 1'bx) $display("unreachable");
`endif
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 100);
        chk("out_timeout", 64'(n < 100), 64'd1);
    endtask

    task automatic wait_busy();
        int n = 0;
        do begin @(negedge clk); n++; end while (!busy && n < 100);
        chk("busy_timeout", 64'(n < 100), 64'd1);
    endtask

    initial begin
        int n;
        logic [W-1:0] pa[3], pb[3];
        logic [2*W-1:0] q[$];
        int n_in, n_out, cyc;
        logic [W-1:0] ra, rb;

        // reset state
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_product", 64'(product), 64'd0);
        chk_ovf("rst_ovf", 1'b0);
        @(negedge clk); rst_n = 1'b1;

        // basic 3*5 with latency
        @(negedge clk); a = 16'd3; b = 16'd5; in_valid = 1'b1; out_ready = 1'b1;
        wait_out(n);
        in_valid = 1'b0;
        chk("basic_latency", 64'(n - 1), 64'(W));
        chk("basic_product", 64'(product), 64'h0000000F);
        chk_ovf("basic_ovf", 1'b0);
        @(negedge clk);
        chk("basic_in_ready", 64'(in_ready), 64'd1);
        chk("basic_out_valid_low", 64'(out_valid), 64'd0);

        // max operands
        a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1;
        wait_out(n);
        in_valid = 1'b0;
        chk("max_product", 64'(product), 64'hFFFE0001);
        chk_ovf("max_ovf", 1'b1);
        @(negedge clk);

        // backpressure with ignored operands
        a = 16'h1234; b = 16'h0010; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        a = 16'd7; b = 16'd7;
        wait_out(n);
        for (int i = 0; i < 10; i++) begin
            chk("bp_product", 64'(product), 64'h00012340);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_product_after", 64'(product), 64'h00012340);
        @(negedge clk);
        chk("bp_no_capture", 64'(busy), 64'd0);

        // asynchronous reset mid-operation
        a = 16'd100; b = 16'd200; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_product", 64'(product), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_busy", 64'(busy), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); a = 16'd100; b = 16'd200; in_valid = 1'b1;
        wait_out(n);
        in_valid = 1'b0;
        chk("arst_redo_product", 64'(product), 64'd20000);
        @(negedge clk);

        // back-to-back with in_valid held high
        pa = '{16'h0000, 16'h8000, 16'h0001};
        pb = '{16'hABCD, 16'h0002, 16'hFFFF};
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = pa[i]; b = pb[i];
            wait_busy();
            wait_out(n);
            chk("b2b_product", 64'(product), 64'(32'(pa[i]) * 32'(pb[i])));
            chk_ovf("b2b_ovf", i == 1);
        end
        in_valid = 1'b0;
        @(negedge clk);

        // random traffic with stalls; expectations queued from accepted operands
        n_in = 0; n_out = 0; cyc = 0;
        while ((n_in < 1000 || q.size() != 0) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                chk("rand_spurious", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    chk("rand_product", 64'(product), 64'(q[0]));
                    chk_ovf("rand_ovf", q[0][2*W-1:W] != '0);
                end
            end
            ra = W'($urandom); rb = W'($urandom);
            a = ra; b = rb;
            in_valid = (n_in < 1000) && ($urandom_range(0, 1) == 1);
            out_ready = $urandom_range(0, 3) != 0;
            if (in_valid && in_ready) begin
                q.push_back(32'(ra) * 32'(rb));
                n_in++;
            end
            if (out_valid && out_ready) begin
                if (q.size() != 0) void'(q.pop_front());
                n_out++;
            end
        end
        in_valid = 1'b0;
        chk("rand_timeout", 64'(cyc < 60000), 64'd1);
        chk("rand_in_count", 64'(n_in), 64'd1000);
        chk("rand_hs_count", 64'(n_out), 64'(n_in));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
